// File: rtl/seq_arb_pkg.sv
// Shared types and default sizing for the sequencer arbiter.
//   state_e        : controller states
//   *_DEF          : default values for the top-level parameters
package seq_arb_pkg;

  localparam int unsigned N_REQ_DEF     = 4;
  localparam int unsigned DATA_W_DEF    = 5;
  localparam int unsigned START_TMO_DEF = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitHi,
    StWaitLo,
    StDone
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : index to start scanning from (0..N_REQ-1), wraps upward
//   any     : at least one request set
//   gnt_idx : first set request found scanning from ptr upward with wrap
module rr_pick
  import seq_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  localparam int unsigned IdxW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IdxW-1:0]  ptr,
  output logic             any,
  output logic [IdxW-1:0]  gnt_idx
);

  int unsigned         pos;
  logic [IdxW-1:0]     pos_idx;

  always_comb begin
    any     = 1'b0;
    gnt_idx = '0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = 32'(ptr) + k;
      // Explicit wrap so non-power-of-two N_REQ stays in range.
      if (pos >= N_REQ) begin
        pos = pos - N_REQ;
      end
      pos_idx = IdxW'(pos);
      if (!any && req[pos_idx]) begin
        any     = 1'b1;
        gnt_idx = pos_idx;
      end
    end
  end

endmodule

// File: rtl/seq_arbiter.sv
// Round-robin arbiter sharing one parallel-to-serial sequencer between N_REQ clients.
//   clk, reset    : clock, asynchronous active-low reset
//   req, req_data : per-client request and flattened data words (held until ack)
//   ack, done     : one-cycle per-client pulses for word capture / serialization finished
//   clr_err       : clears the sticky start-timeout flag
//   baslat, D     : start pulse and registered word to the sequencer
//   mesgul        : sequencer busy
//   gnt_id        : current/last granted client
//   busy, err     : controller not idle / sticky start-timeout flag
module seq_arbiter
  import seq_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = N_REQ_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned START_TMO = START_TMO_DEF,
  localparam int unsigned IdxW     = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        done,
  input  logic                    clr_err,
  output logic                    baslat,
  output logic [DATA_W-1:0]       D,
  input  logic                    mesgul,
  output logic [IdxW-1:0]         gnt_id,
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned CntW = $clog2(START_TMO);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [IdxW-1:0]     gnt_q, gnt_d;
  logic [DATA_W-1:0]   d_q, d_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic                baslat_q, baslat_d;
  logic                err_q, err_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                pick_any;
  logic [IdxW-1:0]     pick_idx;
  logic [IdxW-1:0]     ptr_next;
  logic [DATA_W-1:0]   words [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_words
    assign words[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr_q),
    .any     (pick_any),
    .gnt_idx (pick_idx)
  );

  // Pointer moves just past the client that was served (or timed out).
  assign ptr_next = (gnt_q == IdxW'(N_REQ - 1)) ? '0 : gnt_q + IdxW'(1);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    ack_d    = '0;
    done_d   = '0;
    baslat_d = 1'b0;
    // A timeout set below overrides a simultaneous clear.
    err_d    = err_q & ~clr_err;

    unique case (state_q)
      StIdle: begin
        if (pick_any && !mesgul) begin
          d_d             = words[pick_idx];
          gnt_d           = pick_idx;
          ack_d[pick_idx] = 1'b1;
          baslat_d        = 1'b1;
          state_d         = StStart;
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StWaitHi;
      end
      StWaitHi: begin
        if (mesgul) begin
          state_d = StWaitLo;
        end else if (cnt_q == CntW'(START_TMO - 1)) begin
          err_d   = 1'b1;
          ptr_d   = ptr_next;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitLo: begin
        if (!mesgul) begin
          done_d[gnt_q] = 1'b1;
          state_d       = StDone;
        end
      end
      StDone: begin
        ptr_d   = ptr_next;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      gnt_q    <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      ack_q    <= '0;
      done_q   <= '0;
      baslat_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      baslat_q <= baslat_d;
      err_q    <= err_d;
    end
  end

  assign ack    = ack_q;
  assign done   = done_q;
  assign baslat = baslat_q;
  assign D      = d_q;
  assign gnt_id = gnt_q;
  assign busy   = (state_q != StIdle);
  assign err    = err_q;

endmodule

// File: tb/tb_seq_arbiter.sv
// Self-checking bench for seq_arbiter: directed scenarios plus randomized transfers,
// checked against a transaction-level round-robin model.
module tb_seq_arbiter;

  localparam int N   = 4;
  localparam int W   = 5;
  localparam int TMO = 8;
  localparam int IW  = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   req_data = '0;
  logic [N-1:0]     ack;
  logic [N-1:0]     done;
  logic             clr_err = 1'b0;
  logic             baslat;
  logic [W-1:0]     d;
  logic             mesgul = 1'b0;
  logic [IW-1:0]    gnt_id;
  logic             busy;
  logic             err;

  int               n_checks = 0;
  int               n_errors = 0;

  // Model state: requests the bench holds, client words, rr pointer, sticky error.
  logic [N-1:0]     req_vec = '0;
  logic [W-1:0]     data_arr [N];
  int               m_ptr = 0;
  logic             m_err = 1'b0;

  seq_arbiter #(
    .N_REQ     (N),
    .DATA_W    (W),
    .START_TMO (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .done     (done),
    .clr_err  (clr_err),
    .baslat   (baslat),
    .D        (d),
    .mesgul   (mesgul),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req();
    req = req_vec;
    for (int i = 0; i < N; i++) begin
      req_data[i*W +: W] = data_arr[IW'(i)];
    end
  endtask

  function automatic int rr_expect(input int p, input logic [N-1:0] rv);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (p + k) % N;
      if (rv[IW'(idx)]) return idx;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ack"}, 32'(ack), 32'(0));
    check_eq({tag, "_done"}, 32'(done), 32'(0));
    check_eq({tag, "_baslat"}, 32'(baslat), 32'(0));
    check_eq({tag, "_d"}, 32'(d), 32'(0));
    check_eq({tag, "_gnt"}, 32'(gnt_id), 32'(0));
    check_eq({tag, "_busy"}, 32'(busy), 32'(0));
    check_eq({tag, "_err"}, 32'(err), 32'(0));
  endtask

  // One arbitration round, starting with the DUT idle. req_vec must be non-zero.
  //   guard : cycles mesgul is held high in IDLE before release
  //   lat   : cycles from the WAIT_HI entry until mesgul rises (1..TMO)
  //   tmo   : never raise mesgul; clr_tmo also pulses clr_err on the timeout edge
  //   hold  : granted client keeps req after ack
  //   abort : pull reset mid-busy phase
  task automatic transfer(input int guard, input int lat, input bit tmo, input bit clr_tmo,
                          input bit hold, input bit abort);
    int g;
    g = rr_expect(m_ptr, req_vec);
    drive_req();
    mesgul = 1'b1;
    for (int i = 0; i < guard; i++) begin
      step();
      check_eq("guard_ack", 32'(ack), 32'(0));
      check_eq("guard_busy", 32'(busy), 32'(0));
    end
    mesgul = 1'b0;
    step();
    check_eq("grant_ack", 32'(ack), 32'(1) << g);
    check_eq("grant_baslat", 32'(baslat), 32'(1));
    check_eq("grant_d", 32'(d), 32'(data_arr[IW'(g)]));
    check_eq("grant_id", 32'(gnt_id), 32'(g));
    check_eq("grant_busy", 32'(busy), 32'(1));
    if (!hold) req_vec[IW'(g)] = 1'b0;
    drive_req();
    step();
    check_eq("start_baslat", 32'(baslat), 32'(0));
    check_eq("start_ack", 32'(ack), 32'(0));
    if (tmo) begin
      for (int i = 1; i <= TMO; i++) begin
        if (i == TMO && clr_tmo) clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        if (i < TMO) begin
          check_eq("tmo_busy", 32'(busy), 32'(1));
          check_eq("tmo_err_pre", 32'(err), 32'(m_err));
        end
      end
      m_err = 1'b1;
      m_ptr = (g + 1) % N;
      check_eq("tmo_err", 32'(err), 32'(m_err));
      check_eq("tmo_idle", 32'(busy), 32'(0));
      check_eq("tmo_done", 32'(done), 32'(0));
      return;
    end
    for (int i = 1; i < lat; i++) begin
      step();
      check_eq("wait_hi_done", 32'(done), 32'(0));
      check_eq("wait_hi_err", 32'(err), 32'(m_err));
    end
    mesgul = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("seq_done", 32'(done), 32'(0));
      check_eq("seq_busy", 32'(busy), 32'(1));
      if (abort && i == 2) begin
        reset = 1'b0;
        #1;
        check_all_zero("abort");
        mesgul = 1'b0;
        req_vec = '0;
        drive_req();
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_ptr = 0;
        m_err = 1'b0;
        for (int j = 0; j < 3; j++) begin
          step();
          check_eq("abort_done", 32'(done), 32'(0));
          check_eq("abort_busy", 32'(busy), 32'(0));
        end
        return;
      end
    end
    mesgul = 1'b0;
    step();
    check_eq("done_pulse", 32'(done), 32'(1) << g);
    check_eq("done_ack", 32'(ack), 32'(0));
    step();
    check_eq("done_clear", 32'(done), 32'(0));
    check_eq("done_idle", 32'(busy), 32'(0));
    m_ptr = (g + 1) % N;
  endtask

  task automatic pulse_clr();
    req = '0;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    m_err = 1'b0;
    check_eq("clr_err", 32'(err), 32'(m_err));
  endtask

  initial begin
    for (int i = 0; i < N; i++) data_arr[IW'(i)] = '0;

    // Reset held with all requests up.
    reset = 1'b0;
    req = 4'b1111;
    step();
    step();
    check_all_zero("reset");
    req = '0;
    reset = 1'b1;
    step();
    check_eq("post_reset_ack", 32'(ack), 32'(0));

    // All four from ptr=0, each dropping after ack: order 0,1,2,3.
    for (int i = 0; i < N; i++) data_arr[IW'(i)] = W'(1 << i);
    req_vec = 4'b1111;
    for (int i = 0; i < N; i++) transfer(0, 2, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single request with a known word.
    req_vec = 4'b0010;
    data_arr[1] = 5'b01101;
    transfer(0, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fairness: 0 and 2 held continuously.
    req_vec = 4'b0101;
    for (int i = 0; i < 4; i++) transfer(0, 3, 1'b0, 1'b0, 1'b1, 1'b0);
    req_vec = '0;
    drive_req();

    // Start timeout, clear, then timeout coinciding with clr_err.
    req_vec = 4'b1000;
    transfer(0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_clr();
    req_vec = 4'b1000;
    transfer(0, 1, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse_clr();

    // Latency boundary: mesgul rises just before the timeout would fire.
    req_vec = 4'b0100;
    transfer(0, TMO, 1'b0, 1'b0, 1'b0, 1'b0);

    // Busy guard in IDLE.
    req_vec = 4'b0001;
    transfer(3, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-serialization.
    req_vec = 4'b0110;
    transfer(0, 1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized rounds.
    for (int r = 0; r < 40; r++) begin
      req_vec = req_vec | N'($urandom_range(0, 15));
      if (req_vec == '0) req_vec = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) data_arr[IW'(i)] = W'($urandom);
      transfer($urandom_range(0, 2), $urandom_range(1, TMO), ($urandom_range(0, 7) == 0),
               bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'b0);
      if (m_err && $urandom_range(0, 1) == 1) pulse_clr();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
